// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Sequential ALU execution stage. It accepts an operation code and two operands
// through a start/ready handshake. Single-cycle operations finish at the accept
// edge. MUL runs an iterative shift-add multiplier for DATA_WIDTH cycles. Every
// completion shows a one-cycle done_o pulse.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   start_i          request valid; accepted when start_i && ready_o at clk edge
//   ALU_Operation_i  4-bit operation code, sampled on accept
//   A_i, B_i         operands, sampled on accept
//   ready_o          high only while idle
//   busy_o           high while multiplying or presenting a result
//   done_o           one-cycle pulse when ALU_Result_o/Zero_o are fresh
//   ALU_Result_o     registered result, held until the next completion
//   Zero_o           registered zero/branch flag, held until the next completion
module alu_exec_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [3:0]            ALU_Operation_i,
   input  logic [DATA_WIDTH-1:0] A_i,
   input  logic [DATA_WIDTH-1:0] B_i,
   output logic                  ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] ALU_Result_o,
   output logic                  Zero_o
);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_BNE = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_OR  = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_SRL = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_BEQ = 4'b1001;
   localparam logic [3:0] OP_BGE = 4'b1010;
   localparam logic [3:0] OP_LUI = 4'b1011;

   localparam int CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

   state_t                state;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic [CNT_WIDTH-1:0]  cnt;

   logic [DATA_WIDTH-1:0] diff;
   logic [DATA_WIDTH-1:0] single_result;
   logic                  single_zero;
   logic [DATA_WIDTH-1:0] mul_sum;

   assign diff = A_i - B_i;

   // The accumulator value after the current multiply step. The final step uses
   // this value directly so that the result is ready on the last MUL edge.
   assign mul_sum = acc + (mplier[0] ? mcand : '0);

   // Result and flag of every single-cycle operation, computed from the live
   // operands so that they can be registered on the accept edge. Branch codes
   // replace the generic result==0 flag with their own comparison. MUL and the
   // undefined codes give zero here. MUL never takes this path.
   always_comb begin
      single_result = '0;
      single_zero   = 1'b0;
      case (ALU_Operation_i)
         OP_ADD:  single_result = A_i + B_i;
         OP_SUB:  single_result = diff;
         OP_SLL:  single_result = A_i << B_i[SHAMT_WIDTH-1:0];
         OP_SRL:  single_result = A_i >> B_i[SHAMT_WIDTH-1:0];
         OP_OR:   single_result = A_i | B_i;
         OP_AND:  single_result = A_i & B_i;
         OP_XOR:  single_result = A_i ^ B_i;
         OP_LUI:  single_result = B_i;
         OP_BNE:  single_result = diff;
         OP_BEQ:  single_result = diff;
         OP_BGE:  single_result = diff;
         default: single_result = '0;
      endcase
      case (ALU_Operation_i)
         OP_BNE:  single_zero = (A_i != B_i);
         OP_BEQ:  single_zero = (A_i == B_i);
         OP_BGE:  single_zero = ($signed(A_i) >= $signed(B_i));
         default: single_zero = (single_result == '0);
      endcase
   end

   // Control FSM and datapath registers. The handshake outputs are registered
   // next to the state so that they always match it. ready_o is high only in
   // IDLE. busy_o is high in MUL and DONE. done_o is high in DONE.
   // In MUL, each edge adds the shifted multiplicand when the current
   // multiplier bit is set. The multiplier bit is then shifted out. The result
   // and flag are written only on a completion edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         ready_o      <= 1'b1;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         ALU_Result_o <= '0;
         Zero_o       <= 1'b0;
         acc          <= '0;
         mcand        <= '0;
         mplier       <= '0;
         cnt          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  ready_o <= 1'b0;
                  busy_o  <= 1'b1;
                  if (ALU_Operation_i == OP_MUL) begin
                     acc    <= '0;
                     mcand  <= A_i;
                     mplier <= B_i;
                     cnt    <= '0;
                     state  <= MUL;
                  end else begin
                     ALU_Result_o <= single_result;
                     Zero_o       <= single_zero;
                     done_o       <= 1'b1;
                     state        <= DONE;
                  end
               end
            end
            MUL: begin
               acc    <= mul_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  ALU_Result_o <= mul_sum;
                  Zero_o       <= (mul_sum == '0);
                  done_o       <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               ready_o <= 1'b1;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               ready_o <= 1'b1;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
